// File: rtl/gpio_in_conditioner.sv
// Input conditioning for GPIO pins: two-flop synchronizer, per-pin debounce,
// and sticky rise/fall event flags with per-pin enables and clears.
module gpio_in_conditioner #(
    parameter int N_PINS          = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic [N_PINS-1:0] i_pins,
    input  logic [N_PINS-1:0] i_rise_en,
    input  logic [N_PINS-1:0] i_fall_en,
    input  logic [N_PINS-1:0] i_edge_clr,
    output logic [N_PINS-1:0] o_level,
    output logic [N_PINS-1:0] o_rise,
    output logic [N_PINS-1:0] o_fall,
    output logic              o_irq
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    genvar gi;
    generate
        for (gi = 0; gi < N_PINS; gi++) begin : g_pin
            logic             sync1_reg;
            logic             sync2_reg;
            logic             level_reg;
            logic             rise_reg;
            logic             fall_reg;
            logic [CNT_W-1:0] cnt_reg;

            logic             level_next;
            logic             rise_next;
            logic             fall_next;
            logic [CNT_W-1:0] cnt_next;
            logic             differ;
            logic             expire;

            always_comb begin
                differ     = (sync2_reg != level_reg);
                expire     = differ && (cnt_reg == CNT_LAST);
                level_next = level_reg;
                cnt_next   = '0;
                if (expire) begin
                    level_next = sync2_reg;
                end else if (differ) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            // An event landing in the same cycle as a clear keeps the flag set.
            always_comb begin
                rise_next = rise_reg;
                fall_next = fall_reg;
                if (i_edge_clr[gi]) begin
                    rise_next = 1'b0;
                    fall_next = 1'b0;
                end
                if (expire && sync2_reg && i_rise_en[gi]) begin
                    rise_next = 1'b1;
                end
                if (expire && !sync2_reg && i_fall_en[gi]) begin
                    fall_next = 1'b1;
                end
            end

            always_ff @(posedge clk or negedge aresetn) begin
                if (!aresetn) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    level_reg <= 1'b0;
                    rise_reg  <= 1'b0;
                    fall_reg  <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= i_pins[gi];
                    sync2_reg <= sync1_reg;
                    level_reg <= level_next;
                    rise_reg  <= rise_next;
                    fall_reg  <= fall_next;
                    cnt_reg   <= cnt_next;
                end
            end

            assign o_level[gi] = level_reg;
            assign o_rise[gi]  = rise_reg;
            assign o_fall[gi]  = fall_reg;
        end
    endgenerate

    assign o_irq = |(o_rise | o_fall);

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Bench for gpio_in_conditioner: directed test-plan steps followed by random
// pin activity, all checked each cycle against a sample-history model.
module tb_gpio_in_conditioner;

    localparam int N  = 8;
    localparam int DC = 4;

    logic         clk = 1'b0;
    logic         aresetn;
    logic [N-1:0] i_pins;
    logic [N-1:0] i_rise_en;
    logic [N-1:0] i_fall_en;
    logic [N-1:0] i_edge_clr;
    logic [N-1:0] o_level;
    logic [N-1:0] o_rise;
    logic [N-1:0] o_fall;
    logic         o_irq;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: synchronizer stages, the last DC synchronized samples seen
    // by the debouncer, and the resulting level and flags.
    logic [N-1:0] m_s1, m_s2, m_level, m_rise, m_fall;
    logic         m_hist [N][DC];

    gpio_in_conditioner #(
        .N_PINS(N),
        .DEBOUNCE_CYCLES(DC),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .aresetn(aresetn),
        .i_pins(i_pins),
        .i_rise_en(i_rise_en),
        .i_fall_en(i_fall_en),
        .i_edge_clr(i_edge_clr),
        .o_level(o_level),
        .o_rise(o_rise),
        .o_fall(o_fall),
        .o_irq(o_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_level = '0; m_rise = '0; m_fall = '0;
        for (int n = 0; n < N; n++)
            for (int k = 0; k < DC; k++)
                m_hist[n][k] = 1'b0;
    endtask

    // Level flips once the last DC synchronized samples all disagree with it.
    task automatic model_edge();
        for (int n = 0; n < N; n++) begin
            logic flip, set_r, set_f;
            for (int k = DC - 1; k > 0; k--) m_hist[n][k] = m_hist[n][k-1];
            m_hist[n][0] = m_s2[n];
            flip = 1'b1;
            for (int k = 0; k < DC; k++)
                if (m_hist[n][k] == m_level[n]) flip = 1'b0;
            set_r = 1'b0;
            set_f = 1'b0;
            if (flip) begin
                m_level[n] = ~m_level[n];
                set_r = m_level[n] & i_rise_en[n];
                set_f = ~m_level[n] & i_fall_en[n];
            end
            m_rise[n] = set_r ? 1'b1 : (i_edge_clr[n] ? 1'b0 : m_rise[n]);
            m_fall[n] = set_f ? 1'b1 : (i_edge_clr[n] ? 1'b0 : m_fall[n]);
        end
        m_s2 = m_s1;
        m_s1 = i_pins;
    endtask

    task automatic check_model();
        chk("model_level", o_level, m_level);
        chk("model_rise", o_rise, m_rise);
        chk("model_fall", o_fall, m_fall);
        chk("model_irq", {7'd0, o_irq}, {7'd0, |(m_rise | m_fall)});
    endtask

    task automatic tick();
        @(posedge clk);
        if (aresetn) model_edge();
        else model_reset();
        #1;
        check_model();
    endtask

    // Called just after a tick: reset is asserted and released between edges.
    task automatic async_reset();
        aresetn = 1'b0;
        #1;
        model_reset();
        chk("async_rst_level", o_level, 8'h00);
        chk("async_rst_rise", o_rise, 8'h00);
        chk("async_rst_fall", o_fall, 8'h00);
        chk("async_rst_irq", {7'd0, o_irq}, 8'h00);
        #1;
        aresetn = 1'b1;
    endtask

    initial begin
        aresetn    = 1'b0;
        i_pins     = 8'hFF;
        i_rise_en  = 8'hFF;
        i_fall_en  = 8'hFF;
        i_edge_clr = 8'h00;
        model_reset();

        // Reset with all pins high, then the full debounce latency.
        repeat (3) begin
            tick();
            chk("in_reset_level", o_level, 8'h00);
            chk("in_reset_irq", {7'd0, o_irq}, 8'h00);
        end
        aresetn = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("rst_release_level", o_level, (k >= 6) ? 8'hFF : 8'h00);
            chk("rst_release_rise", o_rise, (k >= 6) ? 8'hFF : 8'h00);
        end
        chk("rst_release_irq", {7'd0, o_irq}, 8'h01);
        i_edge_clr = 8'hFF;
        tick();
        i_edge_clr = 8'h00;
        chk("clear_all_rise", o_rise, 8'h00);

        // Drop all pins with fall capture disabled.
        i_fall_en = 8'h00;
        i_pins    = 8'h00;
        repeat (8) tick();
        chk("all_low_level", o_level, 8'h00);
        chk("all_low_fall", o_fall, 8'h00);

        // Clean rise on pin 0.
        i_rise_en = 8'h01;
        i_pins    = 8'h01;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("rise0_level", o_level & 8'h01, (k >= 6) ? 8'h01 : 8'h00);
            chk("rise0_flag", o_rise & 8'h01, (k >= 6) ? 8'h01 : 8'h00);
            chk("rise0_fall", o_fall, 8'h00);
        end

        // Glitch rejection on pin 3: a 3-cycle pulse, then a 4-cycle pulse.
        i_edge_clr = 8'h01;
        tick();
        i_edge_clr = 8'h00;
        chk("glitch_pre_irq", {7'd0, o_irq}, 8'h00);
        i_pins = 8'h09;
        repeat (3) tick();
        i_pins = 8'h01;
        repeat (8) begin
            tick();
            chk("glitch3_level", o_level & 8'h08, 8'h00);
            chk("glitch3_irq", {7'd0, o_irq}, 8'h00);
        end
        i_pins = 8'h09;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 4) i_pins = 8'h01;
            chk("pulse4_level", o_level & 8'h08, (k >= 6 && k < 10) ? 8'h08 : 8'h00);
        end

        // Fall on pin 2 with capture disabled is never latched later.
        i_pins = 8'h05;
        repeat (8) tick();
        i_pins = 8'h01;
        repeat (8) tick();
        chk("nofall_level", o_level & 8'h04, 8'h00);
        chk("nofall_flag", o_fall & 8'h04, 8'h00);
        i_fall_en = 8'hFF;
        repeat (3) tick();
        chk("nofall_late_flag", o_fall & 8'h04, 8'h00);

        // Clear coincident with pin 1's rise event: set wins; next clear wins.
        i_rise_en = 8'h02;
        i_pins    = 8'h03;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 5) i_edge_clr = 8'h02;
        end
        chk("setwins_rise", o_rise & 8'h02, 8'h02);
        tick();
        i_edge_clr = 8'h00;
        chk("clear_rise", o_rise & 8'h02, 8'h00);
        chk("clear_irq", {7'd0, o_irq}, 8'h00);

        // Reset in the middle of pin 5's debounce count.
        i_pins = 8'h23;
        repeat (4) tick();
        async_reset();
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("midcount_level", o_level, (k >= 6) ? 8'h23 : 8'h00);
            chk("midcount_rise", o_rise, (k >= 6) ? 8'h02 : 8'h00);
        end

        // Random pin activity, enables, clears and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            i_pins     = i_pins ^ N'($urandom & $urandom & $urandom);
            i_edge_clr = ($urandom_range(0, 9) == 0) ? N'($urandom) : 8'h00;
            if ($urandom_range(0, 15) == 0) i_rise_en = N'($urandom);
            if ($urandom_range(0, 15) == 0) i_fall_en = N'($urandom);
            tick();
            if ($urandom_range(0, 499) == 0) async_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
